guess_generator: RTL and testbench

Brute-force candidate source that drives the guess/guesslen inputs of one MD5 hash pipeline.
- Enumerates every string over a contiguous byte range [CHAR_MIN, CHAR_MAX], from start_len to end_len characters.
- Emits one candidate per clock in the pipeline's packed format, with a valid strobe and an emitted-guess counter.
- Sits between the host control logic and the MD5 pipeline.

---
 rtl/guess_generator.sv | 145 ++++++++++++++
 tb/tb_guess_generator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/guess_generator.sv
// Brute-force candidate source for one MD5 pipeline: enumerates every string over
// [CHAR_MIN, CHAR_MAX] from start_len to end_len characters, one candidate per clock.
module guess_generator #(
  parameter logic [7:0] CHAR_MIN = 8'h61,
  parameter logic [7:0] CHAR_MAX = 8'h7A,
  parameter int         CNT_W    = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [3:0]       start_len,
  input  logic [3:0]       end_len,
  output logic [127:0]     guess,
  output logic [3:0]       guesslen,
  output logic             guess_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] guess_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_p0, state_nxt;
  logic [127:0]     guess_p0, guess_nxt;
  logic [3:0]       len_p0, len_nxt;
  logic [3:0]       endl_p0, endl_nxt;
  logic             vld_p0, vld_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;

  logic [127:0]     inc_guess;
  logic             inc_carry;
  logic [3:0]       eff_start, eff_end;
  logic             last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // First candidate of length n: n copies of CHAR_MIN, zero padding beyond.
  function automatic logic [127:0] min_fill(input logic [3:0] n);
    logic [127:0] g;
    g = '0;
    for (int i = 0; i < 15; i++)
      if (i < int'(n)) g[127-8*i -: 8] = CHAR_MIN;
    return g;
  endfunction

  assign eff_start = (start_len == 4'd0) ? 4'd1  : start_len;
  assign eff_end   = (end_len   == 4'd0) ? 4'd15 : end_len;

  // Ripple increment with the last character as least significant position.
  always_comb begin
    inc_guess = guess_p0;
    inc_carry = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      if (i < int'(len_p0) && inc_carry) begin
        if (guess_p0[127-8*i -: 8] == CHAR_MAX) begin
          inc_guess[127-8*i -: 8] = CHAR_MIN;
        end else begin
          inc_guess[127-8*i -: 8] = guess_p0[127-8*i -: 8] + 8'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  // Carry out of the full string at the final length means all chars are CHAR_MAX.
  assign last = inc_carry && (len_p0 == endl_p0);

  always_comb begin
    state_nxt = state_p0;
    guess_nxt = guess_p0;
    len_nxt   = len_p0;
    endl_nxt  = endl_p0;
    vld_nxt   = 1'b0;
    cnt_nxt   = cnt_p0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state_p0)
        IDLE, DONE: begin
          if (start) begin
            endl_nxt = eff_end;
            if (eff_start <= eff_end) begin
              state_nxt = RUN;
              guess_nxt = min_fill(eff_start);
              len_nxt   = eff_start;
              vld_nxt   = 1'b1;
              cnt_nxt   = CNT_W'(1);
            end else begin
              state_nxt = DONE;
              cnt_nxt   = '0;
            end
          end
        end
        RUN: begin
          if (!hold) begin
            if (last) begin
              state_nxt = DONE;
            end else if (inc_carry) begin
              len_nxt   = len_p0 + 4'd1;
              guess_nxt = min_fill(len_p0 + 4'd1);
              vld_nxt   = 1'b1;
              cnt_nxt   = sat_inc(cnt_p0);
            end else begin
              guess_nxt = inc_guess;
              vld_nxt   = 1'b1;
              cnt_nxt   = sat_inc(cnt_p0);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: state and candidate registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      guess_p0 <= '0;
      len_p0   <= '0;
      endl_p0  <= '0;
      vld_p0   <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      guess_p0 <= guess_nxt;
      len_p0   <= len_nxt;
      endl_p0  <= endl_nxt;
      vld_p0   <= vld_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  assign guess       = guess_p0;
  assign guesslen    = len_p0;
  assign guess_valid = vld_p0;
  assign busy        = (state_p0 == RUN);
  assign done        = (state_p0 == DONE);
  assign guess_count = cnt_p0;

endmodule

// File: tb/tb_guess_generator.sv
// Bench for guess_generator with a 3-character charset: table of runs checked
// against an enumeration scoreboard, plus hold, abort and async-reset sequences.
module tb_guess_generator;

  localparam logic [7:0] CMIN = 8'h61;
  localparam logic [7:0] CMAX = 8'h63;
  localparam int         NCH  = 3;
  localparam int         CW   = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic [3:0]    start_len = 4'd1, end_len = 4'd1;
  logic [127:0]  guess;
  logic [3:0]    guesslen;
  logic          guess_valid, busy, done;
  logic [CW-1:0] guess_count;

  guess_generator #(.CHAR_MIN(CMIN), .CHAR_MAX(CMAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .start_len(start_len), .end_len(end_len), .guess(guess), .guesslen(guesslen),
    .guess_valid(guess_valid), .busy(busy), .done(done), .guess_count(guess_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   s;
    logic [3:0]   e;
    int           cnt;
    logic         chk_final;
    logic [127:0] final_g;
  } vec_t;

  typedef struct {
    logic [127:0] g;
    logic [3:0]   l;
  } cand_t;

  cand_t sb[$];
  int    total = 0;
  int    passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Candidate k (0-based) of length L, built as a base-NCH number.
  function automatic logic [127:0] mk(input int L, input int k);
    logic [127:0] g;
    int           r;
    g = '0;
    r = k;
    for (int i = L - 1; i >= 0; i--) begin
      g[127-8*i -: 8] = CMIN + 8'(r % NCH);
      r = r / NCH;
    end
    return g;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] s, input logic [3:0] e);
    start_len = s;
    end_len   = e;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int    es, ee, n, pw, cyc;
    cand_t c;
    sb.delete();
    es = (v.s == 0) ? 1 : int'(v.s);
    ee = (v.e == 0) ? 15 : int'(v.e);
    for (int L = es; L <= ee; L++) begin
      pw = 1;
      for (int j = 0; j < L; j++) pw = pw * NCH;
      for (int k = 0; k < pw; k++) begin
        c.g = mk(L, k);
        c.l = 4'(L);
        sb.push_back(c);
      end
    end
    start_run(v.s, v.e);
    n = 0;
    cyc = 0;
    while (!done && cyc < 500) begin
      if (guess_valid) begin
        n++;
        if (sb.size() == 0) begin
          chk("extra_candidate", 128'(guesslen), 128'(0));
        end else begin
          c = sb.pop_front();
          chk("cand_guess", guess, c.g);
          chk("cand_len", 128'(guesslen), 128'(c.l));
          chk("cand_count", 128'(guess_count), 128'(n));
        end
      end
      step();
      cyc++;
    end
    chk("run_timeout", 128'(cyc >= 500), 128'(0));
    chk("sb_empty", 128'(sb.size()), 128'(0));
    chk("end_done", 128'(done), 128'(1));
    chk("end_busy", 128'(busy), 128'(0));
    chk("end_valid", 128'(guess_valid), 128'(0));
    chk("end_count", 128'(guess_count), 128'(v.cnt));
    if (v.chk_final) chk("end_guess", guess, v.final_g);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{s: 4'd1, e: 4'd2, cnt: 12, chk_final: 1'b1, final_g: {16'h6363, 112'h0}};
    tbl[1] = '{s: 4'd0, e: 4'd1, cnt: 3,  chk_final: 1'b1, final_g: {8'h63, 120'h0}};
    tbl[2] = '{s: 4'd3, e: 4'd2, cnt: 0,  chk_final: 1'b0, final_g: '0};
    tbl[3] = '{s: 4'd2, e: 4'd2, cnt: 9,  chk_final: 1'b1, final_g: {16'h6363, 112'h0}};
    tbl[4] = '{s: 4'd3, e: 4'd3, cnt: 27, chk_final: 1'b1, final_g: {24'h636363, 104'h0}};

    #12;
    chk("rst_guess", guess, '0);
    chk("rst_len", 128'(guesslen), 128'(0));
    chk("rst_valid", 128'(guess_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_count", 128'(guess_count), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Hold after "aa", then the next candidate must be "ab".
    start_run(4'd1, 4'd2);
    chk("h_first", guess, {8'h61, 120'h0});
    step(); step(); step();
    chk("h_aa", guess, {16'h6161, 112'h0});
    chk("h_aa_valid", 128'(guess_valid), 128'(1));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", 128'(guess_valid), 128'(0));
      chk("hold_guess", guess, {16'h6161, 112'h0});
      chk("hold_count", 128'(guess_count), 128'(4));
    end
    hold = 1'b0;
    step();
    chk("post_hold_guess", guess, {16'h6162, 112'h0});
    chk("post_hold_len", 128'(guesslen), 128'(2));
    chk("post_hold_valid", 128'(guess_valid), 128'(1));
    chk("post_hold_count", 128'(guess_count), 128'(5));

    // Abort mid-run, then restart from "a".
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_valid", 128'(guess_valid), 128'(0));
    step();
    chk("idle_valid", 128'(guess_valid), 128'(0));
    start_run(4'd1, 4'd2);
    chk("restart_guess", guess, {8'h61, 120'h0});
    chk("restart_count", 128'(guess_count), 128'(1));
    chk("restart_busy", 128'(busy), 128'(1));

    // Start while running is ignored.
    start_run(4'd3, 4'd3);
    chk("ign_start_guess", guess, {8'h62, 120'h0});
    chk("ign_start_count", 128'(guess_count), 128'(2));

    // Asynchronous reset mid-run.
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_guess", guess, '0);
    chk("arst_len", 128'(guesslen), 128'(0));
    chk("arst_valid", 128'(guess_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_count", 128'(guess_count), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("after_rst_idle", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
